keypad_scan: RTL and testbench

- Scans a 4x4 active-low matrix keypad and debounces it. Emits one-cycle key events: coin values, ticket type, ticket count, confirm and cancel.
- This is the operator-input end of the ticket machine. It is the receive-direction counterpart of the multiplexed seven-segment display scan.
- Key events feed the vending controller, which produces the money, ticket and change values shown on the display.

---
 rtl/keypad_scan.sv | 201 ++++++++++++++++++++
 tb/tb_keypad_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with tick-based press/release debounce.
// Optional auto-repeat of a held key is compiled in when KEY_REPEAT_EN is defined.
module keypad_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_FIRST = 64,
  parameter int REPEAT_NEXT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t           state_r, state_nxt_s;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       col_idx_r, col_idx_nxt_s;
  logic [3:0]       col_r;
  logic [3:0]       cand_r, cand_nxt_s;
  logic [CNT_W-1:0] stable_cnt_r, stable_nxt_s;
  logic [CNT_W-1:0] rel_cnt_r, rel_nxt_s;
  logic [3:0]       key_code_r;
  logic             key_valid_r;
  logic             key_held_r;
  logic             tick_s, advance_s, accept_s, release_s, repeat_s;

  function automatic logic single_low(input logic [3:0] r);
    logic [3:0] low;
    low = ~r;
    return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign tick_s    = (div_r == DIV_LAST);
  assign col       = col_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

  // Next-state logic: all decisions happen only on a scan tick.
  always_comb begin
    state_nxt_s  = state_r;
    cand_nxt_s   = cand_r;
    stable_nxt_s = stable_cnt_r;
    rel_nxt_s    = rel_cnt_r;
    advance_s    = 1'b0;
    accept_s     = 1'b0;
    release_s    = 1'b0;
    if (tick_s) begin
      case (state_r)
        SCAN: begin
          if (row == 4'hF) begin
            advance_s = 1'b1;
          end else if (single_low(row)) begin
            cand_nxt_s   = row;
            stable_nxt_s = CNT_W'(1);
            if (CNT_W'(1) == CNT_DONE) begin
              accept_s = 1'b1;
            end else begin
              state_nxt_s = DEBOUNCE;
            end
          end else begin
            advance_s = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row != cand_r) begin
            state_nxt_s  = SCAN;
            stable_nxt_s = {CNT_W{1'b0}};
            advance_s    = 1'b1;
          end else if (stable_cnt_r + CNT_W'(1) == CNT_DONE) begin
            accept_s = 1'b1;
          end else begin
            stable_nxt_s = stable_cnt_r + CNT_W'(1);
          end
        end
        HOLD: begin
          if (row != 4'hF) begin
            state_nxt_s = HOLD;
          end else if (CNT_W'(1) == CNT_DONE) begin
            release_s = 1'b1;
          end else begin
            state_nxt_s = RELEASE;
            rel_nxt_s   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (row != 4'hF) begin
            state_nxt_s = HOLD;
            rel_nxt_s   = {CNT_W{1'b0}};
          end else if (rel_cnt_r + CNT_W'(1) == CNT_DONE) begin
            release_s = 1'b1;
          end else begin
            rel_nxt_s = rel_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s = SCAN;
        end
      endcase
      if (accept_s) begin
        state_nxt_s  = HOLD;
        stable_nxt_s = {CNT_W{1'b0}};
      end else if (release_s) begin
        state_nxt_s = SCAN;
        rel_nxt_s   = {CNT_W{1'b0}};
        advance_s   = 1'b1;
      end else begin
        state_nxt_s = state_nxt_s;
      end
    end else begin
      state_nxt_s = state_r;
    end
    col_idx_nxt_s = advance_s ? col_idx_r + 2'd1 : col_idx_r;
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FIRST + 1);
  logic [REP_W-1:0] rep_cnt_r, rep_nxt_s;

  // Repeat timer: counts ticks spent staying in HOLD; reloads so later repeats are REPEAT_NEXT apart.
  always_comb begin
    rep_nxt_s = rep_cnt_r;
    repeat_s  = 1'b0;
    if (accept_s) begin
      rep_nxt_s = {REP_W{1'b0}};
    end else if (tick_s && (state_r == HOLD) && (row != 4'hF)) begin
      if (rep_cnt_r + REP_W'(1) == REP_W'(REPEAT_FIRST)) begin
        repeat_s  = 1'b1;
        rep_nxt_s = REP_W'(REPEAT_FIRST - REPEAT_NEXT);
      end else begin
        rep_nxt_s = rep_cnt_r + REP_W'(1);
      end
    end else begin
      rep_nxt_s = rep_cnt_r;
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_r <= {REP_W{1'b0}};
    end else begin
      rep_cnt_r <= rep_nxt_s;
    end
  end
`else
  // Constant zero: the repeat parameters have no effect in this build.
  assign repeat_s = (REPEAT_FIRST < 0) && (REPEAT_NEXT < 0);
`endif

  // State, divider, column drive and registered key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= SCAN;
      div_r        <= {DIV_W{1'b0}};
      col_idx_r    <= 2'd0;
      col_r        <= 4'b1110;
      cand_r       <= 4'hF;
      stable_cnt_r <= {CNT_W{1'b0}};
      rel_cnt_r    <= {CNT_W{1'b0}};
      key_code_r   <= 4'h0;
      key_valid_r  <= 1'b0;
      key_held_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      div_r        <= tick_s ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
      col_idx_r    <= col_idx_nxt_s;
      col_r        <= ~(4'b0001 << col_idx_nxt_s);
      cand_r       <= cand_nxt_s;
      stable_cnt_r <= stable_nxt_s;
      rel_cnt_r    <= rel_nxt_s;
      key_valid_r  <= (accept_s | repeat_s) & ~key_valid_r;
      if (accept_s) begin
        key_code_r <= {low_index(cand_nxt_s), col_idx_r};
        key_held_r <= 1'b1;
      end else if (release_s) begin
        key_held_r <= 1'b0;
      end else begin
        key_held_r <= key_held_r;
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: directed vector table, reset/repeat sequence and
// randomized rows checked cycle by cycle against a tick-level behavioural model.
module tb_keypad_scan;
  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int RF       = 8;
  localparam int RN       = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row = 4'hF;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int total = 0;
  int bad   = 0;

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB), .REPEAT_FIRST(RF), .REPEAT_NEXT(RN)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Behavioural model state, advanced once per clock edge.
  int         m_cyc, m_col, m_run, m_quiet, m_ht;
  logic       m_held, m_valid;
  logic [3:0] m_cand, m_code;

  typedef struct {
    logic [3:0] row;
    int         cycles;
    logic [3:0] col;
    logic       held;
    int         pulses;
    logic [3:0] code;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int row_of(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_edge(input logic r_rst, input logic [3:0] r);
    logic tick;
    m_valid = 1'b0;
    if (r_rst) begin
      m_cyc = 0; m_col = 0; m_run = 0; m_quiet = 0; m_ht = 0;
      m_held = 1'b0; m_cand = 4'hF; m_code = 4'h0;
      return;
    end
    tick = ((m_cyc % SCAN_DIV) == SCAN_DIV - 1);
    m_cyc++;
    if (!tick) return;
    if (!m_held) begin
      if (m_run > 0) begin
        if (r == m_cand) m_run++;
        else begin
          m_run = 0;
          m_col = (m_col + 1) % 4;
        end
      end else if ($countones(~r) == 1) begin
        m_cand = r;
        m_run  = 1;
      end else begin
        m_col = (m_col + 1) % 4;
      end
      if (m_run == DB) begin
        m_run = 0; m_held = 1'b1; m_quiet = 0; m_ht = 0; m_valid = 1'b1;
        m_code = 4'(row_of(r) * 4 + m_col);
      end
    end else if (r == 4'hF) begin
      m_quiet++;
      if (m_quiet == DB) begin
        m_held  = 1'b0;
        m_quiet = 0;
        m_col   = (m_col + 1) % 4;
      end
    end else begin
      if (m_quiet == 0) begin
        m_ht++;
`ifdef KEY_REPEAT_EN
        if (m_ht >= RF && ((m_ht - RF) % RN) == 0) m_valid = 1'b1;
`endif
      end
      m_quiet = 0;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rs);
    logic [3:0] one;
    logic [3:0] exp_col;
    row = r;
    rst = rs;
    @(posedge clk);
    model_edge(rs, r);
    @(negedge clk);
    one     = 4'b0001;
    exp_col = ~(one << m_col);
    chk("model_col", col, exp_col);
    chk("model_valid", key_valid, m_valid);
    chk("model_held", key_held, m_held);
    chk("model_code", key_code, m_code);
  endtask

  initial begin
    int         pulses;
    int         pos[$];
    int         exp_pos[$];
    int         sel, len, b1, b2;
    logic [3:0] pat, one;

    tv[0]  = '{4'hF,    4,  4'b1101, 1'b0, 0, 4'd0};
    tv[1]  = '{4'hF,    4,  4'b1011, 1'b0, 0, 4'd0};
    tv[2]  = '{4'b1101, 12, 4'b1011, 1'b1, 1, 4'd6};
    tv[3]  = '{4'b1101, 8,  4'b1011, 1'b1, 0, 4'd6};
    tv[4]  = '{4'hF,    8,  4'b1011, 1'b1, 0, 4'd6};
    tv[5]  = '{4'b1101, 4,  4'b1011, 1'b1, 0, 4'd6};
    tv[6]  = '{4'hF,    12, 4'b0111, 1'b0, 0, 4'd6};
    tv[7]  = '{4'hF,    4,  4'b1110, 1'b0, 0, 4'd6};
    tv[8]  = '{4'b1110, 4,  4'b1110, 1'b0, 0, 4'd6};
    tv[9]  = '{4'hF,    4,  4'b1101, 1'b0, 0, 4'd6};
    tv[10] = '{4'b1100, 8,  4'b0111, 1'b0, 0, 4'd6};
    tv[11] = '{4'b0111, 12, 4'b0111, 1'b1, 1, 4'd15};

    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    chk("reset_col", col, 4'b1110);
    chk("reset_valid", key_valid, 1'b0);
    chk("reset_held", key_held, 1'b0);
    chk("reset_code", key_code, 4'h0);

    for (int i = 0; i < 12; i++) begin
      pulses = 0;
      for (int c = 0; c < tv[i].cycles; c++) begin
        step(tv[i].row, 1'b0);
        if (key_valid) pulses++;
      end
      chk($sformatf("vec%0d_col", i), col, tv[i].col);
      chk($sformatf("vec%0d_held", i), key_held, tv[i].held);
      chk($sformatf("vec%0d_pulses", i), pulses, tv[i].pulses);
      chk($sformatf("vec%0d_code", i), key_code, tv[i].code);
    end

    // Reset while holding key 15, then hold key 0 for 20 ticks past acceptance.
    step(4'b0111, 1'b1);
    chk("rst_hold_col", col, 4'b1110);
    chk("rst_hold_held", key_held, 1'b0);
    chk("rst_hold_valid", key_valid, 1'b0);
    chk("rst_hold_code", key_code, 4'h0);
    for (int c = 1; c <= 92; c++) begin
      step(4'b1110, 1'b0);
      if (key_valid) pos.push_back(c);
    end
`ifdef KEY_REPEAT_EN
    exp_pos = {12, 44, 60, 76, 92};
`else
    exp_pos = {12};
`endif
    chk("repeat_count", pos.size(), exp_pos.size());
    for (int k = 0; k < pos.size() && k < exp_pos.size(); k++) begin
      chk($sformatf("repeat_pos%0d", k), pos[k], exp_pos[k]);
    end
    chk("repeat_held", key_held, 1'b1);
    chk("repeat_code", key_code, 4'h0);
    for (int c = 0; c < 12; c++) step(4'hF, 1'b0);
    chk("repeat_released", key_held, 1'b0);

    one = 4'b0001;
    for (int seg = 0; seg < 150; seg++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        pat = 4'hF;
      end else if (sel < 8) begin
        pat = ~(one << $urandom_range(0, 3));
      end else if (sel == 8) begin
        b1  = $urandom_range(0, 3);
        b2  = (b1 + 1 + $urandom_range(0, 2)) % 4;
        pat = ~((one << b1) | (one << b2));
      end else begin
        pat = 4'($urandom_range(0, 15));
      end
      len = $urandom_range(1, 24);
      for (int c = 0; c < len; c++) step(pat, 1'b0);
      if ($urandom_range(0, 49) == 0) step(4'hF, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
